// File: rtl/sram_pixel_fetch_pkg.sv
// Shared screen constants and RGB332 -> RGB444 colour expansion for the video pixel stages.
package sram_pixel_fetch_pkg;

    localparam int H_VIS    = 640;
    localparam int V_VIS    = 480;
    localparam int PIPE_LAT = 3;

    // Replicate the top bits of each channel so full-scale inputs map to full-scale outputs.
    function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/sram_pixel_fetch_rgb332_to_444.sv
// Purpose: combinational RGB332 to RGB444 expansion leaf, reused by sprite stages.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module rgb332_to_444
    import sram_pixel_fetch_pkg::*;
(
    input  logic [7:0]  rgb332,
    output logic [11:0] rgb444
);

    assign rgb444 = rgb332_to_444(rgb332);

endmodule

// File: rtl/sram_pixel_fetch.sv
// Purpose: maps the VGA scan position onto a 2x-scaled 320x200 SRAM image and colours each pixel.
// Latency: 3 clk from pixel_x/pixel_y/video_on to rgb_o/rgb_valid.
// Backpressure: none; a new scan position is accepted every clk.
module sram_pixel_fetch
    import sram_pixel_fetch_pkg::*;
#(
    parameter int                    IMG_W      = 320,
    parameter int                    IMG_H      = 200,
    parameter int                    Y_OFFSET   = 40,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 8'hE3,
    parameter logic [11:0]           BG_COLOR   = 12'h000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  video_on,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data_o,
    output logic [11:0]           rgb_o,
    output logic                  rgb_valid
);

    localparam logic [9:0] Y_LO = 10'(Y_OFFSET);
    localparam logic [9:0] Y_HI = 10'(Y_OFFSET + 2 * IMG_H);
    localparam logic [9:0] X_HI = 10'(2 * IMG_W);

    logic                  in_win;
    logic [9:0]            y_rel;
    logic [ADDR_WIDTH-1:0] ix;
    logic [ADDR_WIDTH-1:0] iy;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  vis1, win1, vis2, win2;
    logic [11:0]           rgb_exp;

    assign sram_we = 1'b0;

    // iy*320 as two shifts; the largest address is 63999 so nothing wraps.
    always_comb begin
        in_win   = video_on && (pixel_y >= Y_LO) && (pixel_y < Y_HI) && (pixel_x < X_HI);
        y_rel    = pixel_y - Y_LO;
        ix       = ADDR_WIDTH'(pixel_x >> 1);
        iy       = ADDR_WIDTH'(y_rel >> 1);
        addr_nxt = (iy << 8) + (iy << 6) + ix;
    end

    rgb332_to_444 u_expand (
        .rgb332 (sram_data_o),
        .rgb444 (rgb_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_en   <= 1'b0;
            sram_addr <= '0;
            vis1      <= 1'b0;
            win1      <= 1'b0;
            vis2      <= 1'b0;
            win2      <= 1'b0;
            rgb_o     <= 12'h000;
            rgb_valid <= 1'b0;
        end else begin
            sram_en <= in_win;
            if (in_win) begin
                sram_addr <= addr_nxt;
            end
            vis1 <= video_on;
            win1 <= in_win;
            vis2 <= vis1;
            win2 <= win1;
            // SRAM data is only trusted when the pixel was inside the window.
            if (!vis2) begin
                rgb_o     <= 12'h000;
                rgb_valid <= 1'b0;
            end else if (!win2 || (sram_data_o == KEY_COLOR)) begin
                rgb_o     <= BG_COLOR;
                rgb_valid <= 1'b1;
            end else begin
                rgb_o     <= rgb_exp;
                rgb_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_pixel_fetch.sv
// Directed bench for sram_pixel_fetch with a 1-cycle synchronous SRAM model.
module tb_sram_pixel_fetch;
    import sram_pixel_fetch_pkg::*;

    localparam logic [11:0] BG  = 12'h123;
    localparam logic [7:0]  KEY = 8'hE3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        sram_en;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_data_o = 8'h00;
    logic [11:0] rgb_o;
    logic        rgb_valid;

    logic [7:0]  mem [0:63999];
    int          n_checks = 0;
    int          n_fail   = 0;

    sram_pixel_fetch #(
        .KEY_COLOR (KEY),
        .BG_COLOR  (BG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_data_o (sram_data_o),
        .rgb_o       (rgb_o),
        .rgb_valid   (rgb_valid)
    );

    always #5 clk = ~clk;

    // Data holds its last value while disabled, so stale data is present outside the window.
    always @(posedge clk) begin
        if (sram_en) sram_data_o <= mem[sram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int x, input int y);
        video_on = v;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
    endtask

    function automatic logic in_window(input logic v, input int x, input int y);
        return v && (y >= 40) && (y < 440) && (x < 640);
    endfunction

    function automatic int ref_addr(input int x, input int y);
        return ((y - 40) / 2) * 320 + x / 2;
    endfunction

    // Reference colour: {valid, rgb} for a scan position against the current SRAM contents.
    function automatic logic [12:0] ref_pix(input logic v, input int x, input int y);
        logic [7:0] d;
        if (!v) return 13'h0000;
        if (!in_window(v, x, y)) return {1'b1, BG};
        d = mem[ref_addr(x, y)];
        if (d == KEY) return {1'b1, BG};
        return {1'b1, d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), $urandom_range(0, 639), $urandom_range(0, 479));
            step();
            n_checks++;
            if ({sram_en, sram_we, rgb_valid, rgb_o} !== 15'h0000) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: en=%b we=%b vld=%b rgb=%h, need all 0",
                         i, sram_en, sram_we, rgb_valid, rgb_o);
            end
        end
        reset = 1'b0;
        drive(1'b1, 0, 40);
        for (int i = 1; i <= PIPE_LAT; i++) begin
            step();
            n_checks++;
            if (rgb_valid !== (i == PIPE_LAT)) begin
                n_fail++;
                $display("FAIL reset_first_valid cyc%0d: rgb_valid=%b need %b",
                         i, rgb_valid, (i == PIPE_LAT));
            end
        end
    endtask

    task automatic test_addr();
        int xs [3] = '{0, 3, 639};
        int ys [3] = '{40, 43, 439};
        int ea [3] = '{0, 321, 63999};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, xs[i], ys[i]);
            step();
            n_checks++;
            if (sram_en !== 1'b1 || sram_addr !== 16'(ea[i]) || sram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL addr(%0d,%0d): en=%b we=%b addr=%0d need en=1 we=0 addr=%0d",
                         xs[i], ys[i], sram_en, sram_we, sram_addr, ea[i]);
            end
        end
    endtask

    task automatic test_vertical_edges();
        int ys [2] = '{39, 440};
        for (int i = 0; i < 2; i++) begin
            mem[ref_addr(100, 41)] = 8'h5A;
            drive(1'b1, 100, 41);
            step();
            drive(1'b1, 100, ys[i]);
            step();
            n_checks++;
            if (sram_en !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_en y=%0d: sram_en=%b need 0", ys[i], sram_en);
            end
            step();
            step();
            n_checks++;
            if (rgb_valid !== 1'b1 || rgb_o !== BG) begin
                n_fail++;
                $display("FAIL edge_rgb y=%0d: vld=%b rgb=%h need vld=1 rgb=%h",
                         ys[i], rgb_valid, rgb_o, BG);
            end
        end
    endtask

    task automatic test_colors();
        logic [7:0]  din  [5] = '{8'hE0, 8'h1C, 8'h03, 8'hFF, 8'hE3};
        logic [11:0] dexp [5] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 12'h123};
        for (int i = 0; i < 5; i++) begin
            mem[ref_addr(10, 100)] = din[i];
            drive(1'b1, 10, 100);
            step();
            step();
            step();
            n_checks++;
            if (rgb_valid !== 1'b1 || rgb_o !== dexp[i]) begin
                n_fail++;
                $display("FAIL color %h: vld=%b rgb=%h need vld=1 rgb=%h",
                         din[i], rgb_valid, rgb_o, dexp[i]);
            end
        end
        drive(1'b0, 10, 100);
        step();
        step();
        step();
        n_checks++;
        if (rgb_valid !== 1'b0 || rgb_o !== 12'h000) begin
            n_fail++;
            $display("FAIL blank_key: vld=%b rgb=%h need vld=0 rgb=000", rgb_valid, rgb_o);
        end
    endtask

    // Pipelined scan of selected lines including blanking; outputs checked at the pipeline offset.
    task automatic test_scan();
        int          lines [10] = '{0, 38, 39, 40, 41, 240, 438, 439, 440, 479};
        logic [12:0] expq  [$];
        logic [12:0] e;
        logic        v;
        int          last_addr;
        int          x, y;
        last_addr = int'(sram_addr);
        expq.delete();
        for (int li = 0; li <= 10; li++) begin
            for (int xi = 0; xi < 800; xi++) begin
                if (li == 10) begin
                    if (xi >= 2) break;
                    x = 700; y = 479; v = 1'b0;
                end else begin
                    x = xi; y = lines[li]; v = (x < 640);
                end
                drive(v, x, y);
                expq.push_back(ref_pix(v, x, y));
                if (in_window(v, x, y)) last_addr = ref_addr(x, y);
                step();
                n_checks++;
                if (sram_en !== in_window(v, x, y) || sram_addr !== 16'(last_addr)) begin
                    n_fail++;
                    $display("FAIL scan_addr (%0d,%0d): en=%b addr=%0d need en=%b addr=%0d",
                             x, y, sram_en, sram_addr, in_window(v, x, y), last_addr);
                end
                if (expq.size() == PIPE_LAT) begin
                    e = expq.pop_front();
                    n_checks++;
                    if ({rgb_valid, rgb_o} !== e) begin
                        n_fail++;
                        $display("FAIL scan_rgb at input (%0d,%0d): vld=%b rgb=%h need vld=%b rgb=%h",
                                 x, y, rgb_valid, rgb_o, e[12], e[11:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 64000; a++) mem[a] = 8'(a * 37 + a / 320);
        test_reset();
        test_addr();
        test_vertical_edges();
        test_colors();
        test_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
